aixh_mxc_left_ptile_cell_ispe: RTL

AIXH_MXC_LEFT_PTILE_CELL_ISPE -- requirements
Module: aixh_mxc_left_ptile_cell_ispe

---
 rtl/aixh_mxc_left_ptile_cell_ispe.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/aixh_mxc_left_ptile_cell_ispe.sv
// Left-tile scaled integer PE: decode a 4/8/16-bit operand, multiply by an FP scale, round and emit a 48-bit fixed-point result.
// Optional saturation and sticky overflow flag enabled by defining AIXH_MXC_LISPE_SAT_EN.
module aixh_mxc_left_ptile_cell_ispe #(
  parameter int SM = 8
) (
  input  logic            aixh_core_clk2x,
  input  logic            aixh_core_rst,
  input  logic            enable,
  input  logic            ivalid,
  input  logic            nullify,
  input  logic [1:0]      prec_mode,
  input  logic            uint_mode,
  input  logic [15:0]     iwdata,
  input  logic [SM+4:0]   isdata,
  input  logic            stat_clr,
  output logic            ovalid,
  output logic [47:0]     omdata,
  output logic            ostat_ovf
);

  localparam int PW   = 16 + SM;
  // Wide enough for the largest left shift (40-SM) of a PW-bit product and for the rounding addend.
  localparam int MAGW = (SM > 32) ? (SM + 24) : 56;

  logic [16:0]    v_s;
  logic [15:0]    abs_s;

  logic           v1_r;
  logic [15:0]    abs1_r;
  logic           neg1_r;
  logic [SM-2:0]  mant1_r;
  logic [5:0]     exp1_r;

  logic           v2_r;
  logic [PW-1:0]  prod2_r;
  logic           neg2_r;
  logic [5:0]     exp2_r;

  logic           v3_r;
  logic [47:0]    mag3_r;
  logic           neg3_r;

  logic signed [7:0] sh_s;
  logic [6:0]        rsh_s;
  logic [MAGW-1:0]   wide_s;
  logic [47:0]       mag_s;

  // S1 operand decode to 17-bit signed value and its magnitude
  always_comb begin
    v_s   = 17'd0;
    abs_s = 16'd0;
    case (prec_mode)
      2'b00:   v_s = uint_mode ? {13'd0, iwdata[3:0]} : {{13{iwdata[3]}}, iwdata[3:0]};
      2'b01:   v_s = uint_mode ? {9'd0, iwdata[7:0]}  : {{9{iwdata[7]}}, iwdata[7:0]};
      default: v_s = {iwdata[15], iwdata};
    endcase
    if (nullify) begin
      abs_s = 16'd0;
    end else if (v_s[16]) begin
      abs_s = 16'(17'd0 - v_s);
    end else begin
      abs_s = v_s[15:0];
    end
  end

  // S3 shift by exponent-23-SM; right shifts round half-up on the magnitude
  always_comb begin
    sh_s  = $signed({2'b00, exp2_r}) - $signed(8'(23 + SM));
    rsh_s = 7'(8'd0 - sh_s);
    if (!sh_s[7]) begin
      wide_s = MAGW'(prod2_r) << sh_s[6:0];
    end else begin
      wide_s = (MAGW'(prod2_r) + (MAGW'(1) << (rsh_s - 7'd1))) >> rsh_s;
    end
  end

`ifdef AIXH_MXC_LISPE_SAT_EN
  logic sat_s;

  // Clamp magnitude to 2^47-1 so negated results stay symmetric
  always_comb begin
    sat_s = |wide_s[MAGW-1:47];
    if (sat_s) begin
      mag_s = {1'b0, {47{1'b1}}};
    end else begin
      mag_s = wide_s[47:0];
    end
  end

  // Sticky overflow; a saturating sample entering S3 wins over a coincident clear
  always_ff @(posedge aixh_core_clk2x) begin
    if (aixh_core_rst) begin
      ostat_ovf <= 1'b0;
    end else if (enable && v2_r && sat_s) begin
      ostat_ovf <= 1'b1;
    end else if (enable && stat_clr) begin
      ostat_ovf <= 1'b0;
    end
  end
`else
  logic unused_s;

  // Exact result wrapped modulo 2^48
  always_comb begin
    mag_s = wide_s[47:0];
  end

  assign unused_s  = ^{stat_clr, wide_s[MAGW-1:48]};
  assign ostat_ovf = 1'b0;
`endif

  // Valid chain and output register; omdata only updates on a valid result
  always_ff @(posedge aixh_core_clk2x) begin
    if (aixh_core_rst) begin
      v1_r   <= 1'b0;
      v2_r   <= 1'b0;
      v3_r   <= 1'b0;
      ovalid <= 1'b0;
      omdata <= 48'd0;
    end else if (enable) begin
      v1_r   <= ivalid;
      v2_r   <= v1_r;
      v3_r   <= v2_r;
      ovalid <= v3_r;
      if (v3_r) begin
        omdata <= neg3_r ? (48'd0 - mag3_r) : mag3_r;
      end
    end
  end

  // Data-path stages S1..S3, intentionally without reset
  always_ff @(posedge aixh_core_clk2x) begin
    if (enable) begin
      abs1_r  <= abs_s;
      neg1_r  <= v_s[16] & ~nullify;
      mant1_r <= isdata[SM-2:0];
      exp1_r  <= isdata[SM+4:SM-1];
      prod2_r <= PW'(abs1_r) * PW'({1'b1, mant1_r});
      neg2_r  <= neg1_r;
      exp2_r  <= exp1_r;
      mag3_r  <= mag_s;
      neg3_r  <= neg2_r;
    end
  end

endmodule
